// File: rtl/mdu_seq_mul.sv
// mdu_seq_mul: iterative shift-add multiplier producing the full 2*WIDTH-bit product of srca and srcb.
// Define MDU_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module mdu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t                   state_q;
  logic [2*WIDTH-1:0]       mcand_q, acc_q;
  logic [WIDTH-1:0]         mplier_q, mag_a, mag_b;
  logic [$clog2(WIDTH)-1:0] cnt_q;
  logic                     neg_q, sgn_a, sgn_b, stop;
  always_comb begin
    sgn_a = is_signed & srca[WIDTH-1];
    sgn_b = is_signed & srcb[WIDTH-1];
    mag_a = sgn_a ? -srca : srca;
    mag_b = sgn_b ? -srcb : srcb;
  end
`ifdef MDU_EARLY_TERM_EN
  assign stop = mplier_q == '0;
`else
  assign stop = 1'b0;
`endif
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mcand_q  <= {{WIDTH{1'b0}}, mag_a};
          mplier_q <= mag_b;
          acc_q    <= '0;
          cnt_q    <= '0;
          neg_q    <= sgn_a ^ sgn_b;
          state_q  <= RUN;
        end
        RUN: if (stop) state_q <= FIX;
        else begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == $bits(cnt_q)'(WIDTH-1)) state_q <= FIX;
        end
        FIX: begin
          {result_hi, result_lo} <= neg_q ? -acc_q : acc_q;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_seq_mul.sv
// tb_mdu_seq_mul: table-driven and randomized checks of mdu_seq_mul against an arithmetic product model.
module tb_mdu_seq_mul;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, is_signed = 1'b0;
  logic [31:0] srca = '0, srcb = '0;
  logic        busy, done;
  logic [31:0] result_lo, result_hi;
  int          total = 0, bad = 0;
  logic [63:0] last_exp = '0;

  mdu_seq_mul dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .srca(srca), .srcb(srcb), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a, b;
    logic [63:0] exp;
  } vec_t;

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = 64'($signed(a));
      sb = 64'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int dcyc = -1, busy_bad = 0;
    logic [63:0] res = '0, mid = '0;
    @(negedge clk);
    start = 1'b1; is_signed = s; srca = a; srcb = b;
    for (int c = 1; c <= 60 && dcyc < 0; c++) begin
      @(negedge clk);
      start = 1'b0; srca = $urandom; srcb = $urandom; is_signed = $urandom_range(0, 1);
      if (!busy) busy_bad++;
      if (c == 10) mid = {result_hi, result_lo};
      if (done) begin
        dcyc = c;
        res = {result_hi, result_lo};
      end
    end
    check({name, " held"}, mid, last_exp);
    check({name, " done_cycle"}, 64'(dcyc), 64'd34);
    check({name, " busy_run"}, 64'(busy_bad), 64'd0);
    check({name, " result"}, res, exp);
    @(negedge clk);
    check({name, " idle_after"}, {62'd0, busy, done}, 64'd0);
    check({name, " kept"}, {result_hi, result_lo}, exp);
    last_exp = exp;
  endtask

  initial begin
    vec_t vecs[8];
    int ndone, dc;
    logic [31:0] lo;
    vecs[0] = '{1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[5] = '{1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000};
    vecs[6] = '{1'b0, 32'd0, 32'h1234_5678, 64'd0};
    vecs[7] = '{1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};

    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, result_hi, result_lo}, 66'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 20; i++) begin
      logic s;
      logic [31:0] a, b;
      s = $urandom_range(0, 1); a = $urandom; b = $urandom;
      if (i == 0) a = 32'h8000_0000;
      if (i == 1) b = 32'h7FFF_FFFF;
      run_op($sformatf("rnd%0d", i), s, a, b, ref_mul(s, a, b));
    end

    // start pulses while busy (cycle 5 and the DONE cycle) must be ignored
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; srca = 32'd2; srcb = 32'd2;
    ndone = 0; dc = -1; lo = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 34); srca = 32'd9; srcb = 32'd9;
      if (done) begin ndone++; dc = c; lo = result_lo; end
    end
    start = 1'b0;
    check("busy_win ndone", 64'(ndone), 64'd1);
    check("busy_win cycle", 64'(dc), 64'd34);
    check("busy_win lo", {32'd0, lo}, 64'd4);
    check("busy_win idle", {63'd0, busy}, 64'd0);

    // reset mid-run discards the product and clears results
    @(negedge clk);
    start = 1'b1; srca = 32'd7; srcb = 32'd7;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      reset = (c == 10);
      if (c == 11) begin
        check("mid_reset busy", {63'd0, busy}, 64'd0);
        check("mid_reset result", {result_hi, result_lo}, 64'd0);
      end
      if (done) ndone++;
    end
    check("mid_reset no_done", 64'(ndone), 64'd0);

    // reset and start together: nothing launches
    @(negedge clk);
    reset = 1'b1; start = 1'b1; srca = 32'd3; srcb = 32'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start busy", {63'd0, busy}, 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("rst_start quiet", 64'(ndone), 64'd0);

    last_exp = '0;
    run_op("after_reset", 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
